blue_sequencer: RTL and testbench

Fetch/decode/write-back controller for the Blue datapath. It fetches 16-bit instruction words from memory over a req/ack handshake and holds them in an instruction register. It presents the A and B registers, the opcode and the ZNC flags to the combinational execute stage, then captures that stage's A, B and ZNC results. It also handles load/store, jump and halt instructions locally.

---
 rtl/blue_sequencer_pkg.sv | 46 ++++
 rtl/blue_mem_port.sv | 43 ++++
 rtl/blue_sequencer.sv | 176 +++++++++++++++++
 tb/tb_blue_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blue_sequencer_pkg.sv
// Shared definitions for the Blue sequencer: instruction classes, FSM states,
// flag bit positions and small decode helpers.
package blue_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Instruction classes held in IR[15:12]; 0-7 are execute-stage ALU ops.
    localparam logic [3:0] OP_LDA = 4'd8;
    localparam logic [3:0] OP_STA = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_JMZ = 4'd11;
    localparam logic [3:0] OP_JMN = 4'd12;
    localparam logic [3:0] OP_JMC = 4'd13;
    localparam logic [3:0] OP_NOP = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Bit positions inside the ZNC flag register.
    localparam int unsigned ZNC_Z = 32'd2;
    localparam int unsigned ZNC_N = 32'd1;
    localparam int unsigned ZNC_C = 32'd0;

    function automatic logic is_alu_op(input logic [3:0] cls);
        return (cls[3] == 1'b0);
    endfunction

    // Jump decision from the instruction class and the flags seen at decode.
    function automatic logic jump_taken(input logic [3:0] cls, input logic [2:0] znc);
        logic taken;
        case (cls)
            OP_JMP:  taken = 1'b1;
            OP_JMZ:  taken = znc[ZNC_Z];
            OP_JMN:  taken = znc[ZNC_N];
            OP_JMC:  taken = znc[ZNC_C];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/blue_mem_port.sv
// Memory req/ack holder: latches one request and keeps it stable until ack.
// Shared by instruction fetch and load/store; done marks the ack cycle.
module blue_mem_port
    import blue_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32'd12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [15:0]       issue_wdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              done
);

    // An ack only counts while a request is outstanding.
    assign done = mem_req & mem_ack;

    // Hold the request from issue until ack, then drop it for at least one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
        end else if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else if (issue && !mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= issue_we;
            mem_addr  <= issue_addr;
            mem_wdata <= issue_wdata;
        end
    end

endmodule

// File: rtl/blue_sequencer.sv
// Blue datapath sequencer: fetches instructions, hands ALU ops to the
// combinational execute stage and runs load/store, jumps and halt itself.
module blue_sequencer
    import blue_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32'd12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       ex_a,
    output logic [15:0]       ex_b,
    output logic [15:0]       ex_opcode,
    output logic [2:0]        ex_znc,
    input  logic [15:0]       ex_a_res,
    input  logic [15:0]       ex_b_res,
    input  logic [2:0]        ex_znc_res
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       ir_r;
    logic [15:0]       a_r;
    logic [15:0]       b_r;
    logic [2:0]        znc_r;
    logic              halted_r;

    logic [3:0]        ir_class_s;
    logic [ADDR_W-1:0] ir_addr_s;
    logic              port_issue_s;
    logic              port_we_s;
    logic [ADDR_W-1:0] port_addr_s;
    logic              port_done_s;

    assign ir_class_s = ir_r[15:12];

    // The 12-bit address field is zero-extended or truncated to the PC width.
    generate
        if (ADDR_W > 32'd12) begin : g_addr_ext
            assign ir_addr_s = {{(ADDR_W-32'd12){1'b0}}, ir_r[11:0]};
        end else if (ADDR_W == 32'd12) begin : g_addr_eq
            assign ir_addr_s = ir_r[11:0];
        end else begin : g_addr_trunc
            assign ir_addr_s = ir_r[ADDR_W-1:0];
        end
    endgenerate

    // Request selection: FETCH reads at pc, MEM accesses the instruction's address.
    always_comb begin
        port_issue_s = 1'b0;
        port_we_s    = 1'b0;
        port_addr_s  = pc_r;
        case (state_r)
            ST_FETCH: begin
                port_issue_s = 1'b1;
                port_we_s    = 1'b0;
                port_addr_s  = pc_r;
            end
            ST_MEM: begin
                port_issue_s = 1'b1;
                port_we_s    = (ir_class_s == OP_STA);
                port_addr_s  = ir_addr_s;
            end
            default: begin
                port_issue_s = 1'b0;
                port_we_s    = 1'b0;
                port_addr_s  = pc_r;
            end
        endcase
    end

    blue_mem_port #(
        .ADDR_W(ADDR_W)
    ) u_mem_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (port_issue_s),
        .issue_we    (port_we_s),
        .issue_addr  (port_addr_s),
        .issue_wdata (a_r),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (port_done_s)
    );

    // Sequencer FSM with its architectural registers and halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            ir_r     <= 16'h0000;
            a_r      <= 16'h0000;
            b_r      <= 16'h0000;
            znc_r    <= 3'b000;
            halted_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_r  <= ST_FETCH;
                        halted_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (port_done_s) begin
                        ir_r    <= mem_rdata;
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_alu_op(ir_class_s)) begin
                        state_r <= ST_EXEC;
                    end else begin
                        case (ir_class_s)
                            OP_LDA, OP_STA: state_r <= ST_MEM;
                            OP_NOP:         state_r <= ST_FETCH;
                            OP_HLT: begin
                                state_r  <= ST_HALT;
                                halted_r <= 1'b1;
                            end
                            default: begin
                                if (jump_taken(ir_class_s, znc_r)) begin
                                    pc_r <= ir_addr_s;
                                end
                                state_r <= ST_FETCH;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    a_r     <= ex_a_res;
                    b_r     <= ex_b_res;
                    znc_r   <= ex_znc_res;
                    state_r <= ST_FETCH;
                end
                ST_MEM: begin
                    if (port_done_s) begin
                        if (ir_class_s == OP_LDA) begin
                            a_r          <= mem_rdata;
                            znc_r[ZNC_Z] <= (mem_rdata == 16'h0000);
                            znc_r[ZNC_N] <= mem_rdata[15];
                        end
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    assign halted    = halted_r;
    assign pc        = pc_r;
    assign ex_a      = a_r;
    assign ex_b      = b_r;
    assign ex_opcode = ir_r;
    assign ex_znc    = znc_r;

endmodule

// File: tb/tb_blue_sequencer.sv
// Self-checking bench for blue_sequencer: memory responder with random ack
// delays, a toy execute stage, and an instruction-level reference model.
module tb_blue_sequencer;

    typedef struct packed {
        logic [11:0] addr;
        logic        we;
        logic [15:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic [11:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_opcode;
    logic [2:0]  ex_znc;
    logic [15:0] ex_a_res;
    logic [15:0] ex_b_res;
    logic [2:0]  ex_znc_res;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem  [0:4095];
    logic [15:0] rmem [0:4095];
    txn_t obs_q[$];
    txn_t exp_q[$];

    logic [11:0] m_pc;
    logic [15:0] m_a, m_b, m_ir;
    logic [2:0]  m_znc;

    bit          ack_block    = 1'b0;
    bit          late_ack_req = 1'b0;
    int          wr_delay     = -1;
    bit          active, stable, ack_real;
    int          cnt, delay;
    logic [11:0] t_addr;
    logic        t_we;
    logic [15:0] t_wdata;

    logic [11:0] exp4 [10] = '{12'h000, 12'h810, 12'h001, 12'h100, 12'h811,
                               12'h101, 12'h102, 12'h103, 12'h180, 12'h181};

    // Toy execute stage: add with offset, xor mix, flags from the result.
    function automatic logic [34:0] alu_f(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] ar;
        s  = {1'b0, a} + {1'b0, b};
        ar = s[15:0] + {4'h0, op[11:0]} + 16'h1234;
        return {ar, a ^ b ^ op, (ar == 16'h0000), ar[15], ~s[16]};
    endfunction

    function automatic txn_t mk_txn(input logic [11:0] a, input logic w, input logic [15:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        return t;
    endfunction

    assign {ex_a_res, ex_b_res, ex_znc_res} = alu_f(ex_opcode, ex_a, ex_b);

    blue_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halted(halted), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ex_a(ex_a), .ex_b(ex_b), .ex_opcode(ex_opcode), .ex_znc(ex_znc),
        .ex_a_res(ex_a_res), .ex_b_res(ex_b_res), .ex_znc_res(ex_znc_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder: random or forced ack delay, stability and gap checks.
    initial begin
        mem_ack = 1'b0; mem_rdata = 16'h0000; active = 1'b0; ack_real = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mem_ack = 1'b0; active = 1'b0;
            end else if (late_ack_req) begin
                mem_ack = 1'b1; mem_rdata = 16'h5555; ack_real = 1'b0; late_ack_req = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                if (ack_real) check_eq("req_gap", {31'd0, mem_req}, 32'd0);
                active = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1; stable = 1'b1; cnt = 0;
                    t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
                    delay = (wr_delay >= 0 && mem_we) ? wr_delay : $urandom_range(0, 3);
                end else if (mem_addr !== t_addr || mem_we !== t_we || (t_we && mem_wdata !== t_wdata)) begin
                    stable = 1'b0;
                end
                if (!ack_block && cnt >= delay) begin
                    mem_ack = 1'b1; ack_real = 1'b1;
                    if (t_we) mem[t_addr] = t_wdata;
                    else      mem_rdata = mem[t_addr];
                    obs_q.push_back(mk_txn(t_addr, t_we, t_we ? t_wdata : 16'h0000));
                    check_eq("req_stable", {31'd0, stable}, 32'd1);
                end else begin
                    cnt++;
                end
            end else if (active) begin
                check_eq("req_held", {31'd0, mem_req}, 32'd1);
                active = 1'b0;
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        mem[a] = d; rmem[a] = d;
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_a = 16'h0000; m_b = 16'h0000; m_znc = 3'b000; m_ir = 16'h0000;
    endtask

    // Instruction-level model: runs to HLT, recording expected bus transactions.
    task automatic model_run();
        logic [15:0] ins;
        logic [11:0] tgt;
        logic [34:0] r;
        bit          stop = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 4000 && !stop; n++) begin
            ins = rmem[m_pc];
            exp_q.push_back(mk_txn(m_pc, 1'b0, 16'h0000));
            m_ir = ins; m_pc = m_pc + 12'd1; tgt = ins[11:0];
            if (ins[15] == 1'b0) begin
                r = alu_f(ins, m_a, m_b);
                m_a = r[34:19]; m_b = r[18:3]; m_znc = r[2:0];
            end else begin
                case (ins[15:12])
                    4'd8: begin
                        exp_q.push_back(mk_txn(tgt, 1'b0, 16'h0000));
                        m_a = rmem[tgt]; m_znc[2] = (m_a == 16'h0000); m_znc[1] = m_a[15];
                    end
                    4'd9: begin
                        exp_q.push_back(mk_txn(tgt, 1'b1, m_a));
                        rmem[tgt] = m_a;
                    end
                    4'd10: m_pc = tgt;
                    4'd11: if (m_znc[2]) m_pc = tgt;
                    4'd12: if (m_znc[1]) m_pc = tgt;
                    4'd13: if (m_znc[0]) m_pc = tgt;
                    4'd15: stop = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_halted", {31'd0, halted}, 32'd1);
        check_eq("rst_pc", {20'd0, pc}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_a", {16'd0, ex_a}, 32'd0);
        check_eq("rst_ir", {16'd0, ex_opcode}, 32'd0);
        check_eq("rst_znc", {29'd0, ex_znc}, 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Wait (bounded) for halt; optionally pulse start mid-run, which must be ignored.
    task automatic wait_halt(input bit extra_start);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (halted) break;
            if (extra_start && i == 3) start = 1'b1;
        end
        start = 1'b0;
        check_eq("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic compare_run();
        check_eq("txn_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq($sformatf("txn%0d", i), {3'd0, obs_q[i]}, {3'd0, exp_q[i]});
        check_eq("end_a", {16'd0, ex_a}, {16'd0, m_a});
        check_eq("end_b", {16'd0, ex_b}, {16'd0, m_b});
        check_eq("end_znc", {29'd0, ex_znc}, {29'd0, m_znc});
        check_eq("end_pc", {20'd0, pc}, {20'd0, m_pc});
        check_eq("end_ir", {16'd0, ex_opcode}, {16'd0, m_ir});
    endtask

    task automatic run_program(input bit extra_start);
        obs_q.delete();
        model_run();
        pulse_start();
        wait_halt(extra_start);
        compare_run();
    endtask

    task automatic gen_program();
        int          n;
        int          tg;
        logic [31:0] rnd;
        logic [15:0] w;
        n = $urandom_range(6, 20);
        for (int i = 0; i < n; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 9))
                3: w = {4'h8, 8'h80, rnd[3:0]};
                4: w = {4'h9, 8'h80, rnd[3:0]};
                5, 6: begin
                    tg = i + 1 + $urandom_range(0, 3);
                    if (tg > n) tg = n;
                    w = {4'hA + {2'b00, rnd[5:4]}, tg[11:0]};
                end
                7: w = 16'hE000;
                default: w = {1'b0, rnd[14:0]};
            endcase
            poke(i[11:0], w);
        end
        for (int i = 0; i < 4; i++) poke(n[11:0] + i[11:0], 16'hF000);
        for (int j = 0; j < 16; j++) begin
            rnd = $urandom;
            case (rnd[1:0])
                2'd0:    poke(12'h800 + j[11:0], 16'h0000);
                2'd1:    poke(12'h800 + j[11:0], {1'b1, rnd[16:2]});
                default: poke(12'h800 + j[11:0], rnd[31:16]);
            endcase
        end
    endtask

    initial begin
        bit got;
        int nwr;
        rst_n = 1'b0; start = 1'b0;
        for (int i = 0; i < 4096; i++) poke(i[11:0], 16'h0000);

        // Load then halt.
        do_reset();
        poke(12'h000, 16'h8010); poke(12'h010, 16'h8000); poke(12'h001, 16'hF000);
        run_program(1'b0);
        check_eq("t1_a", {16'd0, ex_a}, 32'h8000);
        check_eq("t1_znc", {29'd0, ex_znc}, 32'd2);
        check_eq("t1_pc", {20'd0, pc}, 32'd2);

        // ALU write-back latency.
        do_reset();
        poke(12'h000, 16'h0000); poke(12'h001, 16'hF000);
        obs_q.delete(); model_run(); pulse_start();
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_ack && mem_req) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t2_ack_seen", {31'd0, got}, 32'd1);
        @(negedge clk); check_eq("t2_decode_a", {16'd0, ex_a}, 32'd0);
        @(negedge clk); check_eq("t2_exec_a", {16'd0, ex_a}, 32'd0);
        @(negedge clk);
        check_eq("t2_wb_a", {16'd0, ex_a}, 32'h1234);
        check_eq("t2_wb_znc", {29'd0, ex_znc}, 32'd1);
        check_eq("t2_pc", {20'd0, pc}, 32'd1);
        wait_halt(1'b0); compare_run();

        // Store with a slow ack.
        do_reset();
        poke(12'h000, 16'h8030); poke(12'h030, 16'hBEEF); poke(12'h001, 16'h9020); poke(12'h002, 16'hF000);
        poke(12'h020, 16'h0000);
        wr_delay = 5;
        run_program(1'b0);
        wr_delay = -1;
        nwr = 0;
        foreach (obs_q[i]) if (obs_q[i].we) begin
            nwr++;
            check_eq("t3_waddr", {20'd0, obs_q[i].addr}, 32'h020);
            check_eq("t3_wdata", {16'd0, obs_q[i].wdata}, 32'hBEEF);
        end
        check_eq("t3_nwrites", nwr, 32'd1);
        check_eq("t3_mem", {16'd0, mem[12'h020]}, 32'hBEEF);

        // Conditional jumps.
        do_reset();
        poke(12'h000, 16'h8810); poke(12'h810, 16'h0000); poke(12'h001, 16'hB100);
        poke(12'h100, 16'h8811); poke(12'h811, 16'h0001); poke(12'h101, 16'hB200);
        poke(12'h102, 16'h0000); poke(12'h103, 16'hD180);
        poke(12'h180, 16'hC1C0); poke(12'h181, 16'hF000);
        run_program(1'b0);
        check_eq("t4_len", obs_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++)
            check_eq($sformatf("t4_addr%0d", i), {20'd0, obs_q[i].addr}, {20'd0, exp4[i]});

        // PC wrap, resuming from HALT at the current pc.
        do_reset();
        poke(12'h000, 16'hAFFE); poke(12'hFFE, 16'hF000);
        run_program(1'b0);
        check_eq("t5_pc_fff", {20'd0, pc}, 32'hFFF);
        poke(12'hFFF, 16'hE000); poke(12'h000, 16'hF000);
        run_program(1'b0);
        check_eq("t5_len", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) begin
            check_eq("t5_first", {20'd0, obs_q[0].addr}, 32'hFFF);
            check_eq("t5_wrap", {20'd0, obs_q[1].addr}, 32'h000);
        end
        check_eq("t5_pc", {20'd0, pc}, 32'd1);

        // Reset during a fetch wait, then a stray ack.
        do_reset();
        poke(12'h000, 16'h0123); poke(12'h001, 16'hF000);
        ack_block = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (mem_req) break;
            @(negedge clk);
        end
        check_eq("t6_req_up", {31'd0, mem_req}, 32'd1);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check_eq("t6_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("t6_halted", {31'd0, halted}, 32'd1);
        ack_block = 1'b0;
        @(negedge clk); rst_n = 1'b1; late_ack_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t6_idle_req", {31'd0, mem_req}, 32'd0);
        end
        check_eq("t6_ir", {16'd0, ex_opcode}, 32'd0);
        check_eq("t6_idle", {31'd0, halted}, 32'd1);
        check_eq("t6_pc", {20'd0, pc}, 32'd0);
        model_reset();
        run_program(1'b0);

        // Random programs against the reference model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            gen_program();
            run_program(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
